// File: rtl/axi_mm_arbiter_n.sv
// rtl/axi_mm_arbiter_n.sv - N-master burst-locked arbiter onto one AXI-MM core port
module axi_mm_arbiter_n_chan #(
    parameter int N_MASTERS = 3,
    parameter int ARB_MODE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] hold_mask,
    input  logic [N_MASTERS-1:0] req_valid,
    input  logic                 req_fire,
    input  logic [31:0]          len_sel,
    input  logic                 beat,
    output logic [N_MASTERS-1:0] grant,
    output logic                 in_req,
    output logic                 in_data,
    output logic                 busy
);
    localparam int PW = $clog2(N_MASTERS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d, win;
    logic [PW-1:0]          ptr_q, ptr_d, widx;
    logic [32:0]            cnt_q, cnt_d;

    function automatic logic [N_MASTERS-1:0] pick(input logic [N_MASTERS-1:0] elig,
                                                  input logic [PW-1:0] ptr);
        logic [N_MASTERS-1:0] res;
        logic                 found;
        logic [PW-1:0]        sel;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            sel = (ARB_MODE == 1) ? PW'((int'(ptr) + k) % N_MASTERS) : PW'(k);
            if (!found && elig[sel]) begin
                res[sel] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        widx = '0;
        for (int k = 0; k < N_MASTERS; k++)
            if (win[k]) widx = PW'(k);
    end

    assign win = pick(req_valid & ~hold_mask, ptr_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (|win) begin
                grant_d = win;
                state_d = S_REQ;
                if (ARB_MODE == 1)
                    ptr_d = (widx == PW'(N_MASTERS - 1)) ? '0 : widx + 1'b1;
            end
            S_REQ: if (req_fire) begin
                // 33 bits so len = 0xFFFF_FFFF gives 2^32 beats without wrapping
                cnt_d   = {1'b0, len_sel} + 33'd1;
                state_d = S_DATA;
            end
            S_DATA: if (beat) begin
                cnt_d = cnt_q - 33'd1;
                if (cnt_q == 33'd1) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant   = grant_q;
    assign in_req  = (state_q == S_REQ);
    assign in_data = (state_q == S_DATA);
    assign busy    = (state_q != S_IDLE);
endmodule

module axi_mm_arbiter_n #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int N_MASTERS  = 3,
    parameter int ARB_MODE   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            hold_mask,
    input  logic [N_MASTERS-1:0]            m_read_request_valid,
    output logic [N_MASTERS-1:0]            m_read_request_ready,
    input  logic [N_MASTERS*AXI_AWIDTH-1:0] m_read_addr,
    input  logic [N_MASTERS*32-1:0]         m_read_len,
    input  logic [N_MASTERS*3-1:0]          m_read_size,
    input  logic [N_MASTERS*2-1:0]          m_read_burst,
    output logic [AXI_DWIDTH-1:0]           m_read_data,
    output logic [N_MASTERS-1:0]            m_read_data_valid,
    input  logic [N_MASTERS-1:0]            m_read_data_ready,
    input  logic [N_MASTERS-1:0]            m_write_request_valid,
    output logic [N_MASTERS-1:0]            m_write_request_ready,
    input  logic [N_MASTERS*AXI_AWIDTH-1:0] m_write_addr,
    input  logic [N_MASTERS*32-1:0]         m_write_len,
    input  logic [N_MASTERS*3-1:0]          m_write_size,
    input  logic [N_MASTERS*2-1:0]          m_write_burst,
    input  logic [N_MASTERS*AXI_DWIDTH-1:0] m_write_data,
    input  logic [N_MASTERS-1:0]            m_write_data_valid,
    output logic [N_MASTERS-1:0]            m_write_data_ready,
    output logic                            core_read_request_valid,
    output logic [AXI_AWIDTH-1:0]           core_read_addr,
    output logic [31:0]                     core_read_len,
    output logic [2:0]                      core_read_size,
    output logic [1:0]                      core_read_burst,
    output logic                            core_read_data_ready,
    input  logic                            core_read_request_ready,
    input  logic [AXI_DWIDTH-1:0]           core_read_data,
    input  logic                            core_read_data_valid,
    output logic                            core_write_request_valid,
    output logic [AXI_AWIDTH-1:0]           core_write_addr,
    output logic [31:0]                     core_write_len,
    output logic [2:0]                      core_write_size,
    output logic [1:0]                      core_write_burst,
    output logic [AXI_DWIDTH-1:0]           core_write_data,
    output logic                            core_write_data_valid,
    input  logic                            core_write_request_ready,
    input  logic                            core_write_data_ready,
    output logic [N_MASTERS-1:0]            rd_grant,
    output logic [N_MASTERS-1:0]            wr_grant,
    output logic                            rd_busy,
    output logic                            wr_busy
);
    logic                  rd_in_req, rd_in_data, wr_in_req, wr_in_data;
    logic [AXI_AWIDTH-1:0] rd_addr_g, wr_addr_g;
    logic [31:0]           rd_len_g, wr_len_g;
    logic [2:0]            rd_size_g, wr_size_g;
    logic [1:0]            rd_burst_g, wr_burst_g;
    logic [AXI_DWIDTH-1:0] wr_data_g;

    always_comb begin
        rd_addr_g = '0; rd_len_g = '0; rd_size_g = '0; rd_burst_g = '0;
        wr_addr_g = '0; wr_len_g = '0; wr_size_g = '0; wr_burst_g = '0;
        wr_data_g = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (rd_grant[i]) begin
                rd_addr_g  = m_read_addr[i*AXI_AWIDTH +: AXI_AWIDTH];
                rd_len_g   = m_read_len[i*32 +: 32];
                rd_size_g  = m_read_size[i*3 +: 3];
                rd_burst_g = m_read_burst[i*2 +: 2];
            end
            if (wr_grant[i]) begin
                wr_addr_g  = m_write_addr[i*AXI_AWIDTH +: AXI_AWIDTH];
                wr_len_g   = m_write_len[i*32 +: 32];
                wr_size_g  = m_write_size[i*3 +: 3];
                wr_burst_g = m_write_burst[i*2 +: 2];
                wr_data_g  = m_write_data[i*AXI_DWIDTH +: AXI_DWIDTH];
            end
        end
    end

    // Read channel: request muxed in REQ, response steered to the owner in DATA
    assign core_read_request_valid = rd_in_req & |(m_read_request_valid & rd_grant);
    assign core_read_addr          = rd_in_req ? rd_addr_g  : '0;
    assign core_read_len           = rd_in_req ? rd_len_g   : '0;
    assign core_read_size          = rd_in_req ? rd_size_g  : '0;
    assign core_read_burst         = rd_in_req ? rd_burst_g : '0;
    assign m_read_request_ready    = {N_MASTERS{rd_in_req & core_read_request_ready}} & rd_grant;
    assign m_read_data             = rd_in_data ? core_read_data : '0;
    assign m_read_data_valid       = {N_MASTERS{rd_in_data & core_read_data_valid}} & rd_grant;
    assign core_read_data_ready    = rd_in_data & |(m_read_data_ready & rd_grant);

    assign core_write_request_valid = wr_in_req & |(m_write_request_valid & wr_grant);
    assign core_write_addr          = wr_in_req ? wr_addr_g  : '0;
    assign core_write_len           = wr_in_req ? wr_len_g   : '0;
    assign core_write_size          = wr_in_req ? wr_size_g  : '0;
    assign core_write_burst         = wr_in_req ? wr_burst_g : '0;
    assign m_write_request_ready    = {N_MASTERS{wr_in_req & core_write_request_ready}} & wr_grant;
    assign core_write_data          = wr_in_data ? wr_data_g : '0;
    assign core_write_data_valid    = wr_in_data & |(m_write_data_valid & wr_grant);
    assign m_write_data_ready       = {N_MASTERS{wr_in_data & core_write_data_ready}} & wr_grant;

    axi_mm_arbiter_n_chan #(.N_MASTERS(N_MASTERS), .ARB_MODE(ARB_MODE)) u_rd (
        .clk       (clk),
        .rst       (rst),
        .hold_mask (hold_mask),
        .req_valid (m_read_request_valid),
        .req_fire  (core_read_request_valid & core_read_request_ready),
        .len_sel   (rd_len_g),
        .beat      (core_read_data_valid & core_read_data_ready),
        .grant     (rd_grant),
        .in_req    (rd_in_req),
        .in_data   (rd_in_data),
        .busy      (rd_busy)
    );

    axi_mm_arbiter_n_chan #(.N_MASTERS(N_MASTERS), .ARB_MODE(ARB_MODE)) u_wr (
        .clk       (clk),
        .rst       (rst),
        .hold_mask (hold_mask),
        .req_valid (m_write_request_valid),
        .req_fire  (core_write_request_valid & core_write_request_ready),
        .len_sel   (wr_len_g),
        .beat      (core_write_data_valid & core_write_data_ready),
        .grant     (wr_grant),
        .in_req    (wr_in_req),
        .in_data   (wr_in_data),
        .busy      (wr_busy)
    );
endmodule

// File: tb/tb_axi_mm_arbiter_n.sv
// tb/tb_axi_mm_arbiter_n.sv - directed-vector bench, fixed-priority and round-robin instances
module tb_axi_mm_arbiter_n;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  hold_mask;
    logic [N-1:0]  m_read_request_valid, m_read_data_ready;
    logic [N*AW-1:0] m_read_addr, m_write_addr;
    logic [N*32-1:0] m_read_len, m_write_len;
    logic [N*3-1:0]  m_read_size, m_write_size;
    logic [N*2-1:0]  m_read_burst, m_write_burst;
    logic [N-1:0]  m_write_request_valid, m_write_data_valid;
    logic [N*DW-1:0] m_write_data;
    logic          core_read_request_ready, core_read_data_valid;
    logic [DW-1:0] core_read_data;
    logic          core_write_request_ready, core_write_data_ready;

    logic [N-1:0]  rrr [2], rdv [2], wrr [2], wdr [2], rdg [2], wrg [2];
    logic [DW-1:0] rdat [2], cwd [2];
    logic          crv [2], crdr [2], cwv [2], cwdv [2], rbusy [2], wbusy [2];
    logic [AW-1:0] cra [2], cwa [2];
    logic [31:0]   crl [2], cwl [2];
    logic [2:0]    crs [2], cws [2];
    logic [1:0]    crb [2], cwb [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0 is fixed priority, instance 1 round-robin; both see the same stimulus
    for (genvar m = 0; m < 2; m++) begin : g_dut
        axi_mm_arbiter_n #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .N_MASTERS(N), .ARB_MODE(m)) u_dut (
            .clk(clk), .rst(rst), .hold_mask(hold_mask),
            .m_read_request_valid(m_read_request_valid), .m_read_request_ready(rrr[m]),
            .m_read_addr(m_read_addr), .m_read_len(m_read_len), .m_read_size(m_read_size),
            .m_read_burst(m_read_burst), .m_read_data(rdat[m]), .m_read_data_valid(rdv[m]),
            .m_read_data_ready(m_read_data_ready),
            .m_write_request_valid(m_write_request_valid), .m_write_request_ready(wrr[m]),
            .m_write_addr(m_write_addr), .m_write_len(m_write_len), .m_write_size(m_write_size),
            .m_write_burst(m_write_burst), .m_write_data(m_write_data),
            .m_write_data_valid(m_write_data_valid), .m_write_data_ready(wdr[m]),
            .core_read_request_valid(crv[m]), .core_read_addr(cra[m]), .core_read_len(crl[m]),
            .core_read_size(crs[m]), .core_read_burst(crb[m]), .core_read_data_ready(crdr[m]),
            .core_read_request_ready(core_read_request_ready), .core_read_data(core_read_data),
            .core_read_data_valid(core_read_data_valid),
            .core_write_request_valid(cwv[m]), .core_write_addr(cwa[m]), .core_write_len(cwl[m]),
            .core_write_size(cws[m]), .core_write_burst(cwb[m]), .core_write_data(cwd[m]),
            .core_write_data_valid(cwdv[m]),
            .core_write_request_ready(core_write_request_ready),
            .core_write_data_ready(core_write_data_ready),
            .rd_grant(rdg[m]), .wr_grant(wrg[m]), .rd_busy(rbusy[m]), .wr_busy(wbusy[m])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_read_request_valid  = '0;
        m_write_request_valid = '0;
        hold_mask = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for a read grant on instance d, checks owner, request mux and beat count.
    task automatic run_burst(input int d, input logic [N-1:0] exp_g, input int exp_beats,
                             input bit drop, input logic [N-1:0] late_set,
                             input logic [N-1:0] late_hold, input string tag, output int idle);
        int beats = 0;
        int guard = 0;
        int stray = 0;
        idle = 0;
        while (rdg[d] == '0 && idle < 20) begin
            tick();
            idle++;
        end
        chk({tag, "_grant"}, rdg[d], exp_g);
        for (int i = 0; i < N; i++)
            if (exp_g[i]) chk({tag, "_addr"}, cra[d], m_read_addr[i*AW +: AW]);
        chk({tag, "_req_ready"}, rrr[d], exp_g);
        tick();
        if (drop) m_read_request_valid = m_read_request_valid & ~exp_g;
        m_read_request_valid = m_read_request_valid | late_set;
        hold_mask = hold_mask | late_hold;
        while (rdg[d] != '0 && guard < 60) begin
            if ((rdv[d] & ~exp_g) != '0) stray++;
            if (core_read_data_valid && crdr[d]) beats++;
            tick();
            guard++;
        end
        chk({tag, "_beats"}, beats, exp_beats);
        chk({tag, "_stray_valid"}, stray, 0);
    endtask

    initial begin
        int idle;
        logic [N-1:0] rr_exp [4];
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        m_read_addr   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        m_write_addr  = {32'h0000_6000, 32'h0000_5000, 32'h0000_4000};
        m_read_len    = {32'd3, 32'd3, 32'd3};
        m_write_len   = '0;
        m_read_size   = {3'd2, 3'd2, 3'd2};
        m_write_size  = {3'd2, 3'd2, 3'd2};
        m_read_burst  = {2'd1, 2'd1, 2'd1};
        m_write_burst = {2'd1, 2'd1, 2'd1};
        m_write_data  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        m_read_data_ready        = '1;
        m_write_data_valid       = '1;
        core_read_request_ready  = 1'b1;
        core_read_data_valid     = 1'b1;
        core_read_data           = 32'h1234_5678;
        core_write_request_ready = 1'b1;
        core_write_data_ready    = 1'b1;
        do_reset();

        chk("rst_rd_grant", rdg[1], 3'b000);
        chk("rst_wr_grant", wrg[1], 3'b000);
        chk("rst_busy", {rbusy[1], wbusy[1]}, 2'b00);
        chk("rst_readies", {rrr[1], wdr[1], crdr[1]}, 7'd0);
        chk("rst_core_out", {crv[1], cra[1], cwd[1], cwdv[1]}, 66'd0);

        // Round-robin with all masters requesting len=3 continuously
        m_read_request_valid = 3'b111;
        for (int b = 0; b < 4; b++) begin
            run_burst(1, rr_exp[b], 4, 1'b0, '0, '0, $sformatf("rr%0d", b), idle);
            if (b > 0) chk($sformatf("rr%0d_idle", b), idle, 1);
        end

        // Fixed priority: 1 beats 2, late master 0 beats 2
        do_reset();
        m_read_len = {32'd1, 32'd1, 32'd1};
        m_read_request_valid = 3'b110;
        run_burst(0, 3'b010, 2, 1'b1, 3'b001, '0, "fp_m1", idle);
        run_burst(0, 3'b001, 2, 1'b1, '0, '0, "fp_m0", idle);
        run_burst(0, 3'b100, 2, 1'b1, '0, '0, "fp_m2", idle);

        // hold_mask mid-burst: master 0 finishes all 8 beats, then is skipped while held
        do_reset();
        m_read_len = {32'd1, 32'd1, 32'd7};
        m_read_request_valid = 3'b011;
        run_burst(0, 3'b001, 8, 1'b0, '0, 3'b001, "hold_m0", idle);
        run_burst(0, 3'b010, 2, 1'b1, '0, '0, "hold_m1", idle);
        tick(); tick(); tick();
        chk("hold_masked_idle", rdg[0], 3'b000);
        hold_mask = '0;
        tick();
        chk("hold_release", rdg[0], 3'b001);

        // Concurrent read by master 0 and write by master 2, single beat each
        do_reset();
        m_read_len  = '0;
        m_write_len = '0;
        m_read_request_valid  = 3'b001;
        m_write_request_valid = 3'b100;
        tick();
        chk("cc_grants", {rdg[1], wrg[1]}, 6'b001_100);
        chk("cc_wr_addr", cwa[1], 32'h0000_6000);
        tick();
        m_read_request_valid  = '0;
        m_write_request_valid = '0;
        chk("cc_rd_valid", rdv[1], 3'b001);
        chk("cc_rd_data", rdat[1], 32'h1234_5678);
        chk("cc_wr_data", {cwdv[1], cwd[1]}, {1'b1, 32'hCCCC_0002});
        chk("cc_wr_ready", wdr[1], 3'b100);
        tick();
        chk("cc_done", {rbusy[1], wbusy[1], rdg[1], wrg[1]}, 8'd0);

        // Write burst of 4 with a 5-cycle core stall after 2 beats
        do_reset();
        m_write_len = {32'd0, 32'd3, 32'd0};
        m_write_request_valid = 3'b010;
        tick();
        tick();
        m_write_request_valid = '0;
        tick();
        tick();
        core_write_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_grant", {wbusy[1], wrg[1]}, 4'b1_010);
        chk("stall_ready", wdr[1], 3'b000);
        core_write_data_ready = 1'b1;
        tick();
        chk("stall_third_beat", wrg[1], 3'b010);
        tick();
        chk("stall_done", {wbusy[1], wrg[1]}, 4'b0_000);

        // Reset while counter is 5, then a fresh master 2 request
        do_reset();
        m_read_len = {32'd0, 32'd0, 32'd7};
        m_read_request_valid = 3'b001;
        tick();
        tick();
        m_read_request_valid = '0;
        tick(); tick(); tick();
        chk("pre_rst_busy", rbusy[1], 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_state", {rdg[1], wrg[1], rbusy[1], wbusy[1]}, 8'd0);
        chk("mid_rst_readies", {rrr[1], rdv[1], crdr[1]}, 7'd0);
        rst = 1'b0;
        m_read_request_valid = 3'b100;
        tick();
        chk("post_rst_grant", rdg[1], 3'b100);
        m_read_request_valid = 3'b101;
        tick(); tick(); tick();
        chk("post_rst_ptr_wrap", rdg[1], 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_mm_arbiter_n.md
Name: axi_mm_arbiter_n

Overview:
- N-master arbiter between DMA/accelerator-class clients and the single core-side port of the AXI memory-mapped adapter.
- Arbitrates read and write channels independently. Each grant is locked for the whole burst.
- Supports fixed-priority or round-robin selection, plus a runtime per-master exclusion mask. The mask generalises the existing accelerator-busy gating.

Parameters:
- AXI_AWIDTH, 32, address width.
- AXI_DWIDTH, 32, data width.
- N_MASTERS, 3, number of client masters (2..8).
- ARB_MODE, 1, selection policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- hold_mask  in  N_MASTERS  bit i=1 excludes master i from new grants.
- m_read_request_valid / m_read_request_ready  in / out  N_MASTERS  per-master read request handshake.
- m_read_addr  in  N_MASTERS*AXI_AWIDTH  flattened; master i at slice [i*AXI_AWIDTH +: AXI_AWIDTH].
- m_read_len  in  N_MASTERS*32  beats minus one.
- m_read_size  in  N_MASTERS*3.
- m_read_burst  in  N_MASTERS*2.
- m_read_data  out  AXI_DWIDTH  broadcast to all masters.
- m_read_data_valid  out  N_MASTERS.
- m_read_data_ready  in  N_MASTERS.
- m_write_request_valid / m_write_request_ready  in / out  N_MASTERS.
- m_write_addr, m_write_len, m_write_size, m_write_burst  in  same flattened widths as read.
- m_write_data  in  N_MASTERS*AXI_DWIDTH.
- m_write_data_valid  in  N_MASTERS.
- m_write_data_ready  out  N_MASTERS.
- core_read_request_valid, core_read_addr, core_read_len, core_read_size, core_read_burst, core_read_data_ready  out  1 / AXI_AWIDTH / 32 / 3 / 2 / 1.
- core_read_request_ready, core_read_data, core_read_data_valid  in  1 / AXI_DWIDTH / 1.
- core_write_request_valid, core_write_addr, core_write_len, core_write_size, core_write_burst, core_write_data, core_write_data_valid  out.
- core_write_request_ready, core_write_data_ready  in.
- rd_grant, wr_grant  out  N_MASTERS  one-hot current owner; 0 when IDLE.
- rd_busy, wr_busy  out  1  channel not IDLE.

Behaviour:
- Two identical, fully independent FSMs, one per channel: IDLE -> REQ -> DATA -> IDLE.
- Reset values:
  - All ready/valid outputs 0, core address/len/size/burst/data outputs 0.
  - Grants 0, busy 0.
  - Round-robin pointers 0, beat counters 0.
- IDLE:
  - Eligible masters are request_valid & ~hold_mask.
  - If any are eligible, register the winner into grant and go to REQ. Arbitration latency is 1 cycle.
  - Winner selection:
    - ARB_MODE=0: lowest eligible index.
    - ARB_MODE=1: first eligible index at or after the pointer, wrapping modulo N_MASTERS. On grant, pointer <= winner+1 (wraps to 0).
- REQ:
  - core_*_request_valid = granted master's valid; addr/len/size/burst muxed from the granted master.
  - Granted master's request_ready = core request_ready; all other request_ready = 0.
  - On handshake: load 33-bit beat counter = len+1, go to DATA.
- DATA (read):
  - m_read_data_valid[g] = core_read_data_valid; other masters' bits are 0.
  - core_read_data_ready = m_read_data_ready[g].
- DATA (write):
  - core_write_data/valid muxed from master g.
  - m_write_data_ready[g] = core_write_data_ready; other masters' bits are 0.
- Beat counting: each data handshake decrements the counter. The handshake that brings it to 0 returns the FSM to IDLE.
  - Grant clears on the following edge.
  - No new grant is issued in that same cycle; minimum 1 idle cycle between bursts.
- hold_mask affects only selection in IDLE. Asserting it mid-burst does not revoke an active grant.
- A master dropping request_valid in REQ is a protocol violation; the grant is held regardless.
- Read and write may be granted to the same master or to different masters simultaneously.
- len = 0: single beat. len = 0xFFFF_FFFF: counter = 2^32, no overflow.
- Simultaneous requests from all masters, round-robin: grants rotate 0,1,2,0,... with no starvation.
- rst asserted mid-burst: both FSMs return to IDLE and all outputs take reset values next edge. Outstanding downstream beats are the adapter's responsibility, since it is reset by the same source.
- Outputs to the core are combinational muxes of registered grant state and master inputs. No data buffering; throughput is 1 beat/cycle.

Test Plan:
- ARB_MODE=1, N=3, all masters request reads with len=3 continuously -> grants 0,1,2,0. Each grant covers exactly 4 data beats, 1 idle cycle between bursts, no data_valid on non-granted masters.
- ARB_MODE=0, masters 1 and 2 request together -> master 1 granted. After its burst ends, master 2 granted. If master 0 requests during master 1's burst, master 0 wins the next grant over master 2.
- hold_mask=3'b001 while master 0 is mid-burst with len=7 -> all 8 beats complete. Master 0 is not re-granted while masked; master 1 is granted next.
- Concurrent read by master 0 and write by master 2, len=0 -> rd_grant=001 and wr_grant=100 simultaneously. Each channel completes 1 beat, then both return to IDLE.
- Core stalls data ready 5 cycles mid-burst -> counter holds, grant holds, and the burst resumes on the remaining beats.
- rst pulse during DATA with counter=5 -> next cycle: grants 0, busy 0, all readies 0, round-robin pointer 0. A fresh request from master 2 is then granted.
